// File: rtl/acc_cpu_core.sv
// Accumulator CPU core with internal program/data RAM, a host load/read-back port,
// start/halt control, Z/C flags, conditional jumps and optional single-step.
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              zero,
  output logic              carry,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_PAUSE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LD  = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND  = 4'h4, OP_OR  = 4'h5, OP_STO = 4'h6, OP_JMP = 4'h7,
    OP_JZ   = 4'h8, OP_JC  = 4'h9, OP_HALT = 4'hF
  } op_t;

  state_t              st;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   ir;
  logic [ADDR_W-1:0]   pc;
  logic                z_flag;
  logic                c_flag;

  op_t                 opcode;
  logic [ADDR_W-1:0]   opnd_addr;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;

  assign opcode    = op_t'(ir[DATA_W-1 -: 4]);
  assign opnd_addr = ir[ADDR_W-1:0];
  assign opnd      = mem[opnd_addr];

  // One extra bit carries the ADD carry-out / SUB borrow.
  // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, opnd};
    diff = {1'b0, acc} - {1'b0, opnd};
  end

  // NOTE: RAM has no reset branch; resetting it would turn it into flops and the host
  // relies on contents surviving a reset anyway.
  always_ff @(posedge clk) begin
    if (ld_we && !busy)
      mem[ld_addr] <= ld_data;
    else if (st == S_EXEC && opcode == OP_STO)
      mem[opnd_addr] <= acc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      st     <= S_IDLE;
      acc    <= '0;
      pc     <= '0;
      ir     <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE, S_HALTED: begin
          if (start) begin
            st     <= S_FETCH;
            pc     <= '0;
            acc    <= '0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
          end
        end
        S_FETCH: begin
          ir <= mem[pc];
          pc <= pc + ADDR_W'(1);
          st <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_LD:  begin acc <= opnd; z_flag <= (opnd == '0); end
            OP_ADD: begin
              acc    <= sum[DATA_W-1:0];
              c_flag <= sum[DATA_W];
              z_flag <= (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              acc    <= diff[DATA_W-1:0];
              c_flag <= diff[DATA_W];
              z_flag <= (diff[DATA_W-1:0] == '0);
            end
            OP_AND: begin acc <= acc & opnd; z_flag <= ((acc & opnd) == '0); end
            OP_OR:  begin acc <= acc | opnd; z_flag <= ((acc | opnd) == '0); end
            OP_JMP: pc <= opnd_addr;
            OP_JZ:  if (z_flag) pc <= opnd_addr;
            OP_JC:  if (c_flag) pc <= opnd_addr;
            default: ;
          endcase
          if (opcode == OP_HALT) st <= S_HALTED;
          else                   st <= step_mode ? S_PAUSE : S_FETCH;
        end
        S_PAUSE: if (step) st <= S_FETCH;
        default: st <= S_IDLE;
      endcase
    end
  end

  assign rd_data = mem[rd_addr];
  assign acc_out = acc;
  assign pc_out  = pc;
  assign zero    = z_flag;
  assign carry   = c_flag;
  assign busy    = (st == S_FETCH) || (st == S_EXEC) || (st == S_PAUSE);
  assign halted  = (st == S_HALTED);
  assign state   = st;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs plus random programs compared against an
// instruction-level interpreter of the accumulator ISA.
module tb_acc_cpu_core;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          RESET;
  logic          start, step_mode, step, ld_we;
  logic [AW-1:0] ld_addr, rd_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] rd_data, acc_out;
  logic [AW-1:0] pc_out;
  logic          zero, carry, busy, halted;
  logic [2:0]    state;

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .RESET(RESET), .start(start), .step_mode(step_mode), .step(step),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .acc_out(acc_out), .pc_out(pc_out), .zero(zero),
    .carry(carry), .busy(busy), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] prog [DEPTH];

  // Reference model state: ISA interpreter over a copy of the RAM image.
  int m_mem [DEPTH];
  int m_acc, m_pc;
  bit m_z, m_c, m_halt;

  task automatic model_run(input int n);
    int ir, op, a, m;
    m_acc = 0; m_pc = 0; m_z = 0; m_c = 0; m_halt = 0;
    for (int i = 0; i < n && !m_halt; i++) begin
      ir   = m_mem[m_pc];
      op   = ir / 16;
      a    = ir % 16;
      m    = m_mem[a];
      m_pc = (m_pc + 1) % DEPTH;
      case (op)
        1:  begin m_acc = m; m_z = (m_acc == 0); end
        2:  begin m_c = (m_acc + m) > 255; m_acc = (m_acc + m) % 256; m_z = (m_acc == 0); end
        3:  begin m_c = (m_acc < m); m_acc = (m_acc - m + 256) % 256; m_z = (m_acc == 0); end
        4:  begin m_acc = m_acc & m; m_z = (m_acc == 0); end
        5:  begin m_acc = m_acc | m; m_z = (m_acc == 0); end
        6:  m_mem[a] = m_acc;
        7:  m_pc = a;
        8:  if (m_z) m_pc = a;
        9:  if (m_c) m_pc = a;
        15: m_halt = 1;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = prog[i];
      tick();
    end
    ld_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halted(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!halted) check("halt_timeout", halted, 1);
  endtask

  task automatic read_mem(input int a, output logic [DW-1:0] v);
    rd_addr = AW'(a);
    #1;
    v = rd_data;
  endtask

  task automatic load_test1(input logic [DW-1:0] a_init);
    clear_prog();
    prog[0] = 8'h18; prog[1] = 8'h29; prog[2] = 8'h6A; prog[3] = 8'hF0;
    prog[8] = 8'h05; prog[9] = 8'h07; prog[10] = a_init;
  endtask

  initial begin
    int            cyc;
    logic [DW-1:0] v;
    logic [AW-1:0] pc_hold;

    RESET = 1'b0; start = 0; step_mode = 0; step = 0; ld_we = 0;
    ld_addr = '0; ld_data = '0; rd_addr = '0;
    #12;
    RESET = 1'b1;
    #1;

    check("rst_state",  state,   0);
    check("rst_acc",    acc_out, 0);
    check("rst_pc",     pc_out,  0);
    check("rst_flags",  {zero, carry}, 0);
    check("rst_busy",   {busy, halted}, 0);

    // Test 1: LD/ADD/STO/HALT
    load_test1(8'h00);
    load_prog();
    pulse_start();
    check("t1_busy_fetch", {busy, state}, {1'b1, 3'd1});
    wait_halted(40, cyc);
    check("t1_edges", cyc + 1, 9);
    check("t1_acc", acc_out, 8'h0C);
    read_mem(10, v);
    check("t1_memA", v, 8'h0C);
    check("t1_zc", {zero, carry}, 0);
    check("t1_pc", pc_out, 4);

    // Test 2: ADD overflow sets Z and C, JZ taken
    clear_prog();
    prog[0] = 8'h18; prog[1] = 8'h29; prog[2] = 8'h85; prog[3] = 8'hF0;
    prog[4] = 8'h11; prog[5] = 8'hF0; prog[8] = 8'hFF; prog[9] = 8'h01;
    load_prog();
    pulse_start();
    wait_halted(40, cyc);
    check("t2_acc", acc_out, 8'h00);
    check("t2_zc", {zero, carry}, 2'b11);
    check("t2_pc", pc_out, 6);

    // Test 3: SUB borrow; M0 written in the same cycle start is sampled (NOP -> LD 8)
    clear_prog();
    prog[1] = 8'h39; prog[2] = 8'hF0; prog[8] = 8'h03; prog[9] = 8'h05;
    load_prog();
    ld_we = 1'b1; ld_addr = 4'h0; ld_data = 8'h18; start = 1'b1;
    tick();
    ld_we = 1'b0; start = 1'b0;
    wait_halted(40, cyc);
    check("t3_acc", acc_out, 8'hFE);
    check("t3_zc", {zero, carry}, 2'b01);

    // Test 4: JMP F, LD 0 at F, pc wraps
    clear_prog();
    prog[0] = 8'h7F; prog[15] = 8'h10;
    load_prog();
    pulse_start();
    repeat (3) tick();
    check("t4_wrap", {state, 1'b0, pc_out}, {3'd2, 1'b0, 4'h0});
    repeat (20) tick();
    check("t4_acc", acc_out, 8'h7F);
    check("t4_busy", busy, 1);
    do_reset();
    #1;
    check("t4_reset", state, 0);

    // Test 5: single-step
    load_test1(8'h00);
    load_prog();
    step_mode = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      if (k < 3) begin
        check($sformatf("t5_pause%0d", k), state, 3);
        pc_hold = pc_out;
        repeat (3) tick();
        check($sformatf("t5_hold%0d", k), {state, 1'b0, pc_out}, {3'd3, 1'b0, pc_hold});
        if (k == 0) begin
          ld_we = 1'b1; ld_addr = 4'hA; ld_data = 8'h99;
          tick();
          ld_we = 1'b0;
          read_mem(10, v);
          check("t5_ld_ignored", v, 8'h00);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
      end
    end
    check("t5_halted", halted, 1);
    check("t5_acc", acc_out, 8'h0C);
    step_mode = 1'b0;

    // Test 6: reset during EXEC of STO
    load_test1(8'h55);
    load_prog();
    pulse_start();
    cyc = 0;
    while (!(state == 3'd2 && pc_out == 4'd3) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t6_at_sto", {state, 1'b0, pc_out}, {3'd2, 1'b0, 4'd3});
    #2;
    RESET = 1'b0;
    #1;
    check("t6_rst_state", state, 0);
    check("t6_rst_acc", acc_out, 0);
    read_mem(10, v);
    check("t6_memA_kept", v, 8'h55);
    RESET = 1'b1;
    pulse_start();
    wait_halted(40, cyc);
    read_mem(10, v);
    check("t6_rerun_memA", v, 8'h0C);
    check("t6_rerun_acc", acc_out, 8'h0C);

    // Random programs versus the ISA interpreter
    for (int it = 0; it < 10; it++) begin
      int n_instr;
      n_instr = 24;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        prog[i]  = DW'($urandom);
        m_mem[i] = int'(prog[i]);
      end
      load_prog();
      pulse_start();
      repeat (2 * n_instr) tick();
      model_run(n_instr);
      check($sformatf("r%0d_acc", it),    acc_out, m_acc);
      check($sformatf("r%0d_pc", it),     pc_out,  m_pc);
      check($sformatf("r%0d_zc", it),     {zero, carry}, {m_z, m_c});
      check($sformatf("r%0d_halted", it), halted,  m_halt);
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        read_mem(i, v);
        check($sformatf("r%0d_mem%0d", it, i), v, m_mem[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
